// File: rtl/spi_peripheral.sv
// Purpose: SPI target. Oversamples PCLK/CS_n/COPI on clk, supports CPOL/CPHA modes 0-3, and shifts whole words MSB-first.
// Latency: CS_n fall to BUSY/CIPO_OE/first CIPO bit is SYNC_STAGES+1 clk; CS_n rise to RX_VALID is SYNC_STAGES+2 clk.
// Backpressure: none on the SPI side (the master owns the clock); TX_LOAD is taken only while TX_READY=1, otherwise dropped.
module spi_peripheral #(
    parameter int NUM_BYTES   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           CPOL,
    input  logic                           CPHA,
    input  logic                           PCLK,
    input  logic                           CS_n,
    input  logic                           COPI,
    output logic                           CIPO,
    output logic                           CIPO_OE,
    input  logic [8*NUM_BYTES-1:0]         D_TX,
    input  logic                           TX_LOAD,
    output logic                           TX_READY,
    output logic [8*NUM_BYTES-1:0]         Q_RX,
    output logic                           RX_VALID,
    output logic [$clog2(NUM_BYTES+1)-1:0] BYTE_COUNT,
    output logic                           BUSY,
    output logic                           OVERRUN
);

    localparam int W   = 8 * NUM_BYTES;
    localparam int BCW = $clog2(W + 2);
    localparam int CW  = $clog2(NUM_BYTES + 1);

    // Bit counter limits: W bits fit the shifters, W+1 marks "at least one extra bit seen".
    localparam logic [BCW-1:0] BIT_MAX  = BCW'(W);
    localparam logic [BCW-1:0] BIT_SAT  = BCW'(W + 1);
    localparam logic [BCW-1:0] BYTE_MAX = BCW'(NUM_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;

    // Synchronizer chains; index SYNC_STAGES-1 is the stage the logic looks at.
    logic [SYNC_STAGES-1:0] pclk_sync;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] copi_sync;
    logic                   pclk_q;
    logic                   csn_q;

    logic pclk_s;
    logic csn_s;
    logic copi_s;
    logic pclk_chg;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;
    logic cs_fall;
    logic cs_rise;
    logic start_xfer;

    logic [W-1:0]   pending;
    logic [W-1:0]   tx_shift;
    logic [W-1:0]   rx_shift;
    logic [BCW-1:0] bit_cnt;
    logic           skip_first;
    logic           ovf;

    logic [BCW-1:0] rx_bytes;
    logic [W-1:0]   rx_aligned;

    // Synchronize the asynchronous SPI pins and keep one extra flop of PCLK/CS_n for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_sync <= '0;
            csn_sync  <= '1;
            copi_sync <= '0;
            pclk_q    <= 1'b0;
            csn_q     <= 1'b1;
        end else begin
            pclk_sync <= {pclk_sync[SYNC_STAGES-2:0], PCLK};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], CS_n};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], COPI};
            pclk_q    <= pclk_sync[SYNC_STAGES-1];
            csn_q     <= csn_sync[SYNC_STAGES-1];
        end
    end

    assign pclk_s = pclk_sync[SYNC_STAGES-1];
    assign csn_s  = csn_sync[SYNC_STAGES-1];
    assign copi_s = copi_sync[SYNC_STAGES-1];

    // Leading edge leaves the idle level CPOL, trailing edge returns to it.
    assign pclk_chg   = pclk_s ^ pclk_q;
    assign lead_edge  = pclk_chg & (pclk_s != CPOL);
    assign trail_edge = pclk_chg & (pclk_s == CPOL);

    // CPHA picks which edge samples COPI and which advances CIPO.
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;

    assign cs_fall    = csn_q & ~csn_s;
    assign cs_rise    = ~csn_q & csn_s;
    assign start_xfer = (state == IDLE) && cs_fall;

    // CIPO is simply the MSB of the TX shifter; the shifter is zero outside a transaction.
    assign CIPO = tx_shift[W-1];

    // Whole bytes received, capped at capacity, and the RX word with any partial trailing byte dropped.
    always_comb begin
        rx_bytes = bit_cnt >> 3;
        if (rx_bytes > BYTE_MAX) begin
            rx_bytes = BYTE_MAX;
        end
        if (bit_cnt > BIT_MAX) begin
            rx_aligned = rx_shift;
        end else begin
            rx_aligned = rx_shift >> bit_cnt[2:0];
        end
    end

    // Pending-response register: a load is accepted only when empty; a transaction start empties it.
    // A load in the same cycle as a start wins, so that word stays pending for the next transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            TX_READY <= 1'b1;
        end else begin
            if (start_xfer) begin
                TX_READY <= 1'b1;
            end
            if (TX_LOAD && TX_READY) begin
                pending  <= D_TX;
                TX_READY <= 1'b0;
            end
        end
    end

    // Transaction FSM: IDLE waits for select, SHIFT moves bits on PCLK edges, DONE publishes the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx_shift   <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            skip_first <= 1'b0;
            ovf        <= 1'b0;
            Q_RX       <= '0;
            RX_VALID   <= 1'b0;
            BYTE_COUNT <= '0;
            BUSY       <= 1'b0;
            CIPO_OE    <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            RX_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        // TX_READY=1 means nothing is pending, so the response is all zeros.
                        tx_shift   <= TX_READY ? '0 : pending;
                        rx_shift   <= '0;
                        bit_cnt    <= '0;
                        ovf        <= 1'b0;
                        // With CPHA=1 bit 0 is already on CIPO, so the first leading edge must not shift.
                        skip_first <= CPHA;
                        BUSY       <= 1'b1;
                        CIPO_OE    <= 1'b1;
                        state      <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (sample_edge) begin
                        if (bit_cnt < BIT_MAX) begin
                            rx_shift <= {rx_shift[W-2:0], copi_s};
                        end else begin
                            ovf <= 1'b1;
                        end
                        if (bit_cnt != BIT_SAT) begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                    if (shift_edge) begin
                        if (skip_first) begin
                            skip_first <= 1'b0;
                        end else begin
                            tx_shift <= {tx_shift[W-2:0], 1'b0};
                        end
                    end
                    // A sample in this same cycle still lands because DONE reads the updated shifter.
                    if (cs_rise) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    Q_RX       <= rx_aligned;
                    BYTE_COUNT <= CW'(rx_bytes);
                    OVERRUN    <= ovf;
                    RX_VALID   <= 1'b1;
                    BUSY       <= 1'b0;
                    CIPO_OE    <= 1'b0;
                    tx_shift   <= '0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Purpose: directed bench for spi_peripheral acting as the SPI master, with a word-level model of the response and receive word.
// Latency: checks CS_n rise to RX_VALID against SYNC_STAGES+2 clk.
// Backpressure: exercises TX_LOAD while the pending register is full (must be ignored) and while BUSY.
module tb_spi_peripheral;

    localparam int NB   = 2;
    localparam int SS   = 2;
    localparam int W    = 8 * NB;
    localparam int HALF = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          CPOL;
    logic          CPHA;
    logic          PCLK;
    logic          CS_n;
    logic          COPI;
    logic          CIPO;
    logic          CIPO_OE;
    logic [W-1:0]  D_TX;
    logic          TX_LOAD;
    logic          TX_READY;
    logic [W-1:0]  Q_RX;
    logic          RX_VALID;
    logic [1:0]    BYTE_COUNT;
    logic          BUSY;
    logic          OVERRUN;

    int checks = 0;
    int passes = 0;

    // Model state: pending response word and the expected result of the transaction in flight.
    logic [W-1:0] m_pend;
    bit           m_pend_vld;
    logic [W-1:0] exp_q;
    int           exp_bc;
    bit           exp_ovr;
    bit           exp_armed = 1'b0;

    // Last result seen on RX_VALID, for the literal expectations.
    logic [W-1:0] last_q  = '0;
    int           last_bc = 0;
    bit           last_ovr = 1'b0;

    always #5 clk = ~clk;

    spi_peripheral #(
        .NUM_BYTES   (NB),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .CPOL       (CPOL),
        .CPHA       (CPHA),
        .PCLK       (PCLK),
        .CS_n       (CS_n),
        .COPI       (COPI),
        .CIPO       (CIPO),
        .CIPO_OE    (CIPO_OE),
        .D_TX       (D_TX),
        .TX_LOAD    (TX_LOAD),
        .TX_READY   (TX_READY),
        .Q_RX       (Q_RX),
        .RX_VALID   (RX_VALID),
        .BYTE_COUNT (BYTE_COUNT),
        .BUSY       (BUSY),
        .OVERRUN    (OVERRUN)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Compare process: every RX_VALID pulse must be expected and carry the model's result.
    always @(negedge clk) begin
        if (!rst && RX_VALID) begin
            check("rx_valid_expected", 64'(exp_armed), 64'd1);
            check("q_rx", 64'(Q_RX), 64'(exp_q));
            check("byte_count", 64'(BYTE_COUNT), 64'(exp_bc));
            check("overrun", 64'(OVERRUN), 64'(exp_ovr));
            last_q    = Q_RX;
            last_bc   = int'(BYTE_COUNT);
            last_ovr  = OVERRUN;
            exp_armed = 1'b0;
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, "_cipo"},       64'(CIPO),       64'd0);
        check({tag, "_cipo_oe"},    64'(CIPO_OE),    64'd0);
        check({tag, "_tx_ready"},   64'(TX_READY),   64'd1);
        check({tag, "_q_rx"},       64'(Q_RX),       64'd0);
        check({tag, "_rx_valid"},   64'(RX_VALID),   64'd0);
        check({tag, "_byte_count"}, 64'(BYTE_COUNT), 64'd0);
        check({tag, "_busy"},       64'(BUSY),       64'd0);
        check({tag, "_overrun"},    64'(OVERRUN),    64'd0);
    endtask

    task automatic do_load(input logic [W-1:0] w);
        @(negedge clk);
        D_TX    = w;
        TX_LOAD = 1'b1;
        if (!m_pend_vld) begin
            m_pend     = w;
            m_pend_vld = 1'b1;
        end
        @(negedge clk);
        TX_LOAD = 1'b0;
        check("tx_ready_after_load", 64'(TX_READY), 64'd0);
    endtask

    task automatic do_reset_abort();
        exp_armed = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        reset_checks("abort");
        m_pend_vld = 1'b0;
        CS_n = 1'b1;
        PCLK = CPOL;
        COPI = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // One master transaction. bits[nbits-1] goes out first. load_at/abort_at are bit indices, -1 for never.
    task automatic xfer(input int mode, input int nbits, input logic [31:0] bits,
                        input int load_at, input logic [W-1:0] load_w, input int abort_at);
        logic [W-1:0] txw;
        logic [63:0]  v;
        logic         exp_bit;
        int           k;
        int           lat;
        bit           seen;

        @(negedge clk);
        CPOL = mode[1];
        CPHA = mode[0];
        PCLK = mode[1];
        repeat (4) @(negedge clk);

        // Response: pending word if any, else zeros. Receive word: the first k whole bytes sent, up to capacity.
        txw        = m_pend_vld ? m_pend : '0;
        m_pend_vld = 1'b0;
        k = nbits / 8;
        if (k > NB) k = NB;
        k = k * 8;
        v = 64'(bits);
        exp_q     = (k == 0) ? '0 : W'((v >> (nbits - k)) & ((64'd1 << k) - 64'd1));
        exp_bc    = k / 8;
        exp_ovr   = (nbits > W);
        exp_armed = 1'b1;

        CS_n = 1'b0;
        if (!CPHA && nbits > 0) COPI = bits[nbits-1];
        repeat (HALF) @(negedge clk);
        check("busy_in_xfer", 64'(BUSY), 64'd1);
        check("cipo_oe_in_xfer", 64'(CIPO_OE), 64'd1);

        for (int i = 0; i < nbits; i++) begin
            if (i == load_at) do_load(load_w);
            if (i == abort_at) begin
                do_reset_abort();
                return;
            end
            exp_bit = (i < W) ? txw[W-1-i] : 1'b0;
            if (!CPHA) begin
                check($sformatf("cipo_m%0d_b%0d", mode, i), 64'(CIPO), 64'(exp_bit));
                PCLK = ~CPOL;
                repeat (HALF) @(negedge clk);
                PCLK = CPOL;
                COPI = (i + 1 < nbits) ? bits[nbits-2-i] : 1'b0;
                repeat (HALF) @(negedge clk);
            end else begin
                PCLK = ~CPOL;
                COPI = bits[nbits-1-i];
                repeat (HALF) @(negedge clk);
                check($sformatf("cipo_m%0d_b%0d", mode, i), 64'(CIPO), 64'(exp_bit));
                PCLK = CPOL;
                repeat (HALF) @(negedge clk);
            end
        end

        CS_n = 1'b1;
        COPI = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            lat++;
            if (RX_VALID) seen = 1'b1;
        end
        check("rx_valid_seen", 64'(seen), 64'd1);
        check("rx_latency", 64'(lat), 64'(SS + 2));

        repeat (2) @(negedge clk);
        check("busy_after", 64'(BUSY), 64'd0);
        check("cipo_oe_after", 64'(CIPO_OE), 64'd0);
        check("cipo_after", 64'(CIPO), 64'd0);
        check("tx_ready_after", 64'(TX_READY), 64'(!m_pend_vld));
    endtask

    initial begin
        rst        = 1'b1;
        CS_n       = 1'b1;
        PCLK       = 1'b0;
        COPI       = 1'b0;
        CPOL       = 1'b0;
        CPHA       = 1'b0;
        TX_LOAD    = 1'b0;
        D_TX       = '0;
        m_pend     = '0;
        m_pend_vld = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Same data in all four modes.
        for (int m = 0; m < 4; m++) begin
            do_load(16'hA55A);
            xfer(m, 16, 32'h3C96, -1, '0, -1);
            check($sformatf("lit_q_mode%0d", m), 64'(last_q), 64'h3C96);
            check($sformatf("lit_bc_mode%0d", m), 64'(last_bc), 64'd2);
            check($sformatf("lit_ovr_mode%0d", m), 64'(last_ovr), 64'd0);
        end

        // Nothing loaded: zeros out, one byte in.
        xfer(0, 8, 32'hF0, -1, '0, -1);
        check("lit_q_one_byte", 64'(last_q), 64'h00F0);
        check("lit_bc_one_byte", 64'(last_bc), 64'd1);

        // 20 bits: overrun, CIPO zero past bit 16.
        do_load(16'hFFFF);
        xfer(0, 20, 32'hFFFFF, -1, '0, -1);
        check("lit_q_overrun", 64'(last_q), 64'hFFFF);
        check("lit_bc_overrun", 64'(last_bc), 64'd2);
        check("lit_ovr_overrun", 64'(last_ovr), 64'd1);

        // 11 bits with a load during BUSY; partial byte dropped, loaded word held for later.
        xfer(1, 11, 32'h40D, 4, 16'h1234, -1);
        check("lit_q_partial", 64'(last_q), 64'h0081);
        check("lit_bc_partial", 64'(last_bc), 64'd1);
        check("tx_ready_pending", 64'(TX_READY), 64'd0);

        // A load while full is ignored; the next transaction sends 1234.
        do_load(16'h5555);
        xfer(0, 16, 32'h0F0F, -1, '0, -1);
        check("lit_q_next", 64'(last_q), 64'h0F0F);

        // Reset at bit 5, then a normal transaction.
        do_load(16'hBEEF);
        xfer(0, 16, 32'hFFFF, -1, '0, 5);
        check("no_rx_valid_after_abort", 64'(exp_armed), 64'd0);
        do_load(16'hC33C);
        xfer(3, 16, 32'h5AA5, -1, '0, -1);
        check("lit_q_after_abort", 64'(last_q), 64'h5AA5);

        // Select and deselect with no clock edges.
        xfer(2, 0, 32'h0, -1, '0, -1);
        check("lit_q_empty", 64'(last_q), 64'h0);
        check("lit_bc_empty", 64'(last_bc), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
